// File: rtl/apb_pkg.sv
// Shared APB request/response types and the arbiter FSM state encoding.
package apb_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } apb_arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request searching upward from i_last+1, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = apb_pkg::idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int   w_c;
  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 1; k <= N; k++) begin
      w_c = (int'(i_last) + k) % N;
      if (!w_found && i_req[IW'(w_c)]) begin
        o_idx   = IW'(w_c);
        w_found = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB subordinate among CPU_NB managers with a round-robin grant
// decided in IDLE and held through SETUP/ACCESS.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int CPU_NB = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  apb_req_t  [CPU_NB-1:0] i_apb_s_req,
  output apb_resp_t [CPU_NB-1:0] o_apb_s_resp,
  input  logic      [CPU_NB-1:0] i_apb_s_psel,
  input  logic      [CPU_NB-1:0] i_apb_s_penable,
  output logic      [CPU_NB-1:0] o_apb_s_pready,
  output apb_req_t               o_apb_m_req,
  input  apb_resp_t              i_apb_m_resp,
  output logic                   o_apb_m_psel,
  output logic                   o_apb_m_penable,
  input  logic                   i_apb_m_pready
);

  localparam int IW = idx_w(CPU_NB);

  apb_arb_state_e r_state;
  logic [IW-1:0]  r_grant;
  logic [IW-1:0]  r_last;
  logic [IW-1:0]  w_pick_idx;
  logic           w_pick_vld;
  logic           w_done;

  rr_pick #(.N(CPU_NB), .IW(IW)) u_pick (
    .i_req   (i_apb_s_psel),
    .i_last  (r_last),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_done = (r_state == ARB_ACCESS) && i_apb_m_pready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= IW'(CPU_NB - 1);
    end else begin
      case (r_state)
        ARB_IDLE: if (w_pick_vld) begin
          r_grant <= w_pick_idx;
          r_state <= ARB_SETUP;
        end
        ARB_SETUP: r_state <= ARB_ACCESS;
        ARB_ACCESS: if (w_done) begin
          r_last  <= r_grant;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Outputs forced low while rst is high so an aborted transfer never leaks a pready.
  always_comb begin
    o_apb_m_psel    = 1'b0;
    o_apb_m_penable = 1'b0;
    o_apb_m_req     = '0;
    o_apb_s_pready  = '0;
    o_apb_s_resp    = '0;
    if (!rst && r_state != ARB_IDLE) begin
      o_apb_m_psel    = 1'b1;
      o_apb_m_penable = (r_state == ARB_ACCESS);
      o_apb_m_req     = i_apb_s_req[r_grant];
      // A manager that abandoned its select still completes downstream but gets no ready.
      if (w_done && i_apb_s_psel[r_grant]) begin
        o_apb_s_pready[r_grant] = 1'b1;
        o_apb_s_resp[r_grant]   = i_apb_m_resp;
      end
    end
  end

  for (genvar k = 0; k < CPU_NB; k++) begin : g_pen_chk
    a_pen_needs_sel: assert property (@(posedge clk) disable iff (rst)
      i_apb_s_penable[k] |-> i_apb_s_psel[k]);
  end

endmodule
